// File: rtl/image_loader.sv
// rtl/image_loader.sv - ping-pong frame assembler for signed fixed-point pixel beats
// Purpose: packs LANES-wide input beats into NUM_PIXELS-pixel frames held in two
//          banks, and presents each completed frame to a consumer.
// Ports:
//   clock, reset              - rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready        - beat handshake (in_ready comes from registers only)
//   in_pixels, in_last        - beat data (lane 0 = lowest pixel index), early frame end
//   frame_valid, frame_ready  - frame handshake
//   frame_pixels              - presented frame, stable while stalled
//   short_frame               - one-cycle pulse after a frame was closed early by in_last
//   frame_count               - frames delivered, wraps 65535 -> 0
module image_loader #(
  parameter int INTEGER_WIDTH  = 16,
  parameter int FRACTION_WIDTH = 16,
  parameter int NUM_PIXELS     = 784,
  parameter int LANES          = 1,
  parameter int ZERO_FILL      = 1
) (
  input  logic                                                     clock,
  input  logic                                                     reset,
  input  logic                                                     in_valid,
  output logic                                                     in_ready,
  input  logic signed [LANES-1:0][INTEGER_WIDTH-1:-FRACTION_WIDTH] in_pixels,
  input  logic                                                     in_last,
  output logic                                                     frame_valid,
  input  logic                                                     frame_ready,
  output logic signed [NUM_PIXELS-1:0][INTEGER_WIDTH-1:-FRACTION_WIDTH] frame_pixels,
  output logic                                                     short_frame,
  output logic [15:0]                                              frame_count
);

  localparam int BEATS = (NUM_PIXELS + LANES - 1) / LANES;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PIW   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int LIW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BCW-1:0] LAST_BC = BCW'(BEATS - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t bank_state [2];
  bank_state_t bank_next  [2];
  logic        wp, wp_next;
  logic        rp, rp_next;
  logic [BCW-1:0] bc, bc_next;
  logic [15:0] count_next;

  logic [NUM_PIXELS-1:0][INTEGER_WIDTH-1:-FRACTION_WIDTH] bank_pix [2];

  logic xfer, consume, last_beat, close, early, zero_tail;
  int   beat_base;

  assign in_ready     = (bank_state[wp] != FULL);
  assign frame_valid  = (bank_state[rp] == FULL);
  assign frame_pixels = bank_pix[rp];

  assign xfer      = in_valid & in_ready;
  assign consume   = frame_valid & frame_ready;
  assign last_beat = (bc == LAST_BC);
  assign close     = xfer & (last_beat | in_last);
  assign early     = xfer & in_last & ~last_beat;
  assign zero_tail = early & (ZERO_FILL != 0);
  assign beat_base = int'(bc) * LANES;

  // A closing write and a consume can never target the same bank: a FULL bank
  // cannot accept a beat, and only a FULL bank can be consumed.
  always_comb begin
    bank_next[0] = bank_state[0];
    bank_next[1] = bank_state[1];
    wp_next      = wp;
    rp_next      = rp;
    bc_next      = bc;
    count_next   = frame_count;
    if (xfer) begin
      if (close) begin
        bank_next[wp] = FULL;
        wp_next       = ~wp;
        bc_next       = '0;
      end else begin
        bank_next[wp] = FILLING;
        bc_next       = bc + BCW'(1);
      end
    end
    if (consume) begin
      bank_next[rp] = EMPTY;
      rp_next       = ~rp;
      count_next    = frame_count + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      wp            <= 1'b0;
      rp            <= 1'b0;
      bc            <= '0;
      short_frame   <= 1'b0;
      frame_count   <= 16'd0;
    end else begin
      bank_state[0] <= bank_next[0];
      bank_state[1] <= bank_next[1];
      wp            <= wp_next;
      rp            <= rp_next;
      bc            <= bc_next;
      short_frame   <= early;
      frame_count   <= count_next;
    end
  end

  // Lanes whose pixel index falls past the frame end never match a pixel and are
  // dropped. On an early close the tail beyond this beat is cleared in the same
  // write so a short frame never carries stale pixels when zero fill is enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_pix[0] <= '0;
      bank_pix[1] <= '0;
    end else if (xfer) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        if (zero_tail && (p >= beat_base + LANES)) begin
          bank_pix[wp][PIW'(p)] <= '0;
        end
        for (int i = 0; i < LANES; i++) begin
          if (p == beat_base + i) begin
            bank_pix[wp][PIW'(p)] <= in_pixels[LIW'(i)];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// tb/tb_image_loader.sv - randomized scoreboard bench for image_loader
module tb_image_loader;
  localparam int W     = 32;
  localparam int NP    = 10;
  localparam int LN    = 3;
  localparam int BEATS = (NP + LN - 1) / LN;

  typedef logic [NP-1:0][W-1:0] frame_t;
  typedef logic [LN-1:0][W-1:0] beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        in_valid, in_ready, in_last, frame_valid, frame_ready, short_frame;
  beat_t       in_pixels;
  frame_t      frame_pixels;
  logic [15:0] frame_count;

  logic        z_in_valid, z_in_ready, z_in_last, z_frame_valid, z_frame_ready, z_short_frame;
  beat_t       z_in_pixels;
  frame_t      z_frame_pixels;
  logic [15:0] z_frame_count;

  logic        w_in_valid, w_in_ready, w_in_last, w_frame_valid, w_frame_ready, w_short_frame;
  logic [W-1:0] w_in_pixels, w_frame_pixels;
  logic [15:0] w_frame_count;

  image_loader #(.INTEGER_WIDTH(16), .FRACTION_WIDTH(16), .NUM_PIXELS(NP), .LANES(LN), .ZERO_FILL(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
    .in_last(in_last), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_pixels(frame_pixels), .short_frame(short_frame), .frame_count(frame_count));

  image_loader #(.INTEGER_WIDTH(16), .FRACTION_WIDTH(16), .NUM_PIXELS(NP), .LANES(LN), .ZERO_FILL(0)) dut_nofill (
    .clock(clock), .reset(reset), .in_valid(z_in_valid), .in_ready(z_in_ready), .in_pixels(z_in_pixels),
    .in_last(z_in_last), .frame_valid(z_frame_valid), .frame_ready(z_frame_ready),
    .frame_pixels(z_frame_pixels), .short_frame(z_short_frame), .frame_count(z_frame_count));

  image_loader #(.INTEGER_WIDTH(16), .FRACTION_WIDTH(16), .NUM_PIXELS(1), .LANES(1), .ZERO_FILL(1)) dut_wrap (
    .clock(clock), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_pixels(w_in_pixels),
    .in_last(w_in_last), .frame_valid(w_frame_valid), .frame_ready(w_frame_ready),
    .frame_pixels(w_frame_pixels), .short_frame(w_short_frame), .frame_count(w_frame_count));

  int          total = 0;
  int          bad   = 0;
  beat_t       bq[$];
  logic        lq[$];
  int          kq[$];
  frame_t      eq[$];
  int          closed;
  logic        exp_short;
  logic [15:0] exp_count;
  frame_t      zmem [2];
  int          zfr;

  task automatic check(input string tag, input logic [NP*W-1:0] obs, input logic [NP*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Builds one frame of beats; mode 0 = pixel n is n.0, 1 = random, 2 = all 7.0.
  // The expected frame holds written pixels and zero everywhere else.
  task automatic push_frame(input int nb, input int mode, input bit last_on_full);
    frame_t f;
    beat_t  b;
    int     n;
    f = '0;
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < LN; i++) begin
        n = k * LN + i;
        case (mode)
          0:       b[i] = 32'(n) << 16;
          1:       b[i] = $urandom;
          default: b[i] = 32'h0007_0000;
        endcase
        if (n < NP) f[n] = b[i];
      end
      bq.push_back(b);
      kq.push_back(k);
      lq.push_back((k == nb - 1) && ((nb < BEATS) || last_on_full));
    end
    eq.push_back(f);
  endtask

  // One clock of the main instance: drive at the falling edge, check 1 time unit later.
  // The model is a two-frame buffer: closed = frames finished but not yet taken.
  task automatic cyc(input bit v, input bit fr);
    bit xfer, cons;
    in_valid    = v && (bq.size() > 0);
    in_pixels   = in_valid ? bq[0] : beat_t'({$urandom, $urandom, $urandom});
    in_last     = in_valid ? lq[0] : 1'($urandom);
    frame_ready = fr;
    #1;
    check("in_ready", in_ready, closed < 2);
    check("frame_valid", frame_valid, closed > 0);
    check("short_frame", short_frame, exp_short);
    xfer = in_valid && in_ready;
    cons = frame_valid && frame_ready;
    exp_short = 1'b0;
    if (cons) begin
      check("frame pending", eq.size() > 0, 1'b1);
      if (eq.size() > 0) begin
        check("frame_pixels", frame_pixels, eq[0]);
        void'(eq.pop_front());
      end
      closed--;
      exp_count++;
    end
    if (xfer) begin
      if (lq[0] || (kq[0] == BEATS - 1)) closed++;
      exp_short = lq[0] && (kq[0] < BEATS - 1);
      void'(bq.pop_front());
      void'(lq.pop_front());
      void'(kq.pop_front());
    end
    @(negedge clock);
  endtask

  task automatic z_frame(input int nb, input int mode);
    frame_t f;
    beat_t  b;
    int     n;
    f = zmem[zfr % 2];
    check("z in_ready", z_in_ready, 1'b1);
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < LN; i++) begin
        n = k * LN + i;
        b[i] = (mode == 2) ? 32'h0007_0000 : $urandom;
        if (n < NP) f[n] = b[i];
      end
      z_in_valid  = 1'b1;
      z_in_pixels = b;
      z_in_last   = (k == nb - 1) && (nb < BEATS);
      @(negedge clock);
    end
    z_in_valid = 1'b0;
    z_in_last  = 1'b0;
    #1;
    check("z frame_valid", z_frame_valid, 1'b1);
    check("z short_frame", z_short_frame, nb < BEATS);
    check("z frame_pixels", z_frame_pixels, f);
    z_frame_ready = 1'b1;
    @(negedge clock);
    z_frame_ready = 1'b0;
    zmem[zfr % 2] = f;
    zfr++;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stalls;
    int sent;
    int guard;
    in_valid = 0; in_last = 0; in_pixels = '0; frame_ready = 0;
    z_in_valid = 0; z_in_last = 0; z_in_pixels = '0; z_frame_ready = 0;
    w_in_valid = 0; w_in_last = 0; w_in_pixels = '0; w_frame_ready = 0;
    closed = 0; exp_short = 0; exp_count = 0; zfr = 0;
    zmem[0] = '0; zmem[1] = '0;

    @(negedge clock);
    #1;
    check("reset frame_valid", frame_valid, 1'b0);
    check("reset short_frame", short_frame, 1'b0);
    check("reset frame_count", frame_count, 16'd0);
    check("reset frame_pixels", frame_pixels, '0);
    check("reset z frame_pixels", z_frame_pixels, '0);
    reset = 1'b1;
    @(negedge clock);

    // Index pattern, 4 beats, lanes 1-2 of the last beat fall beyond pixel 9.
    push_frame(4, 0, 0);
    repeat (4) cyc(1, 0);
    cyc(0, 1);
    cyc(0, 0);
    check("frame_count after first", frame_count, exp_count);

    // Three frames with no consumer: two fill the banks, the third stalls.
    repeat (3) push_frame(4, 1, 0);
    repeat (11) cyc(1, 0);
    check("stalled beats", bq.size(), 4);
    guard = 0;
    while ((bq.size() > 0 || eq.size() > 0) && guard < 50) begin cyc(1, 1); guard++; end
    check("stall drain", bq.size() + eq.size(), 0);

    // Short frame with zero fill, then a full frame ending with in_last.
    push_frame(2, 2, 0);
    repeat (2) cyc(1, 0);
    cyc(0, 0);
    cyc(0, 1);
    push_frame(4, 1, 1);
    repeat (4) cyc(1, 0);
    cyc(0, 1);
    cyc(0, 0);

    // No zero fill: the short frame keeps the tail of the frame last held in its bank.
    z_frame(4, 1);
    z_frame(4, 1);
    z_frame(2, 2);

    // 100 back-to-back frames with a ready consumer.
    for (int f = 0; f < 100; f++) push_frame(4, 1, 1'($urandom));
    stalls = 0;
    guard  = 0;
    while (bq.size() > 0 && guard < 1000) begin
      if (!in_ready) stalls++;
      cyc(1, 1);
      guard++;
    end
    check("stream in_ready stalls", stalls, 0);
    guard = 0;
    while (eq.size() > 0 && guard < 10) begin cyc(0, 1); guard++; end
    cyc(0, 0);
    check("stream frame_count", frame_count, exp_count);

    // Random frame lengths, random valid gaps and consumer back-pressure.
    for (int f = 0; f < 40; f++) push_frame($urandom_range(1, 4), 1, 1'($urandom));
    guard = 0;
    while ((bq.size() > 0 || eq.size() > 0) && guard < 3000) begin
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0);
      guard++;
    end
    check("random drain", bq.size() + eq.size(), 0);
    cyc(0, 0);
    check("random frame_count", frame_count, exp_count);

    // Reset with one frame held and a second half-written.
    push_frame(4, 1, 0);
    repeat (4) cyc(1, 0);
    push_frame(4, 1, 0);
    repeat (2) cyc(1, 0);
    #2;
    reset = 1'b0;
    #1;
    check("async reset frame_valid", frame_valid, 1'b0);
    check("async reset frame_pixels", frame_pixels, '0);
    check("async reset frame_count", frame_count, 16'd0);
    check("async reset in_ready", in_ready, 1'b1);
    bq.delete(); lq.delete(); kq.delete(); eq.delete();
    closed = 0; exp_short = 0; exp_count = 0;
    in_valid = 0;
    @(negedge clock);
    reset = 1'b1;
    push_frame(4, 1, 0);
    repeat (4) cyc(1, 1);
    cyc(0, 1);
    cyc(0, 0);
    check("post reset frame_count", frame_count, exp_count);

    // Single-pixel frames to walk frame_count to its wrap.
    w_frame_ready = 1'b1;
    sent   = 0;
    stalls = 0;
    guard  = 0;
    while (sent < 65535 && guard < 70000) begin
      w_in_valid  = 1'b1;
      w_in_pixels = 32'(sent);
      #1;
      if (w_in_ready) sent++;
      else stalls++;
      @(negedge clock);
      guard++;
    end
    w_in_valid = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("wrap stalls", stalls, 0);
    check("count at 65535", w_frame_count, 16'hFFFF);
    @(negedge clock);
    w_in_valid  = 1'b1;
    w_in_pixels = 32'h1234_5678;
    @(negedge clock);
    w_in_valid = 1'b0;
    #1;
    check("wrap frame_valid", w_frame_valid, 1'b1);
    check("wrap frame_pixels", w_frame_pixels, 32'h1234_5678);
    @(negedge clock);
    #1;
    check("count wrapped", w_frame_count, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
